// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests and exception info flowing into the
// sequencing controller, and the merged stall vector, flush, redirect PC, watchdog pulse and
// stall-cycle count flowing back out.
//   master : pipeline side (drives requests, consumes control)
//   slave  : controller side (consumes requests, drives control)
interface pipeline_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_timeout;
  logic [31:0] stall_cnt;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i, cnt_clr,
    input  stall, flush, new_pc, bus_timeout, stall_cnt
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i, cnt_clr,
    output stall, flush, new_pc, bus_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencing controller for the 6-stage pipeline (pc, if, id, ex, mem, wb).
// Merges stage stall requests into the shared stall vector, sequences exception flushes with
// a one-cycle RECOVER window, converts a hung data access into a synthetic exception via a
// watchdog, and keeps a saturating stall-cycle counter.
// Ports:
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset; forces all combinational outputs to 0 while high
//   bus  : pipeline_ctrl_if.slave (requests/exception in; stall/flush/new_pc/bus_timeout/
//          stall_cnt out)
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam bit              WdEn   = (TIMEOUT != 0);
  localparam int unsigned     WdW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0]  WdLast = (TIMEOUT == 0) ? '0 : WdW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e         state_q, state_d;
  logic [WdW-1:0] wait_q, wait_d;
  logic [31:0]    cnt_q, cnt_d;

  logic [5:0]  merged;
  logic        exc;
  logic        wd_fire;
  logic        flush;
  logic [5:0]  stall;
  logic [31:0] new_pc;

  always_comb begin
    merged = 6'b000000;
    if (state_q == StRecover) begin
      // Only the if request is real here; id/ex/mem hold flushed bubbles.
      if (bus.stallreq_from_if) merged = 6'b000011;
    end else if (bus.stallreq_from_mem) begin
      merged = 6'b011111;
    end else if (bus.stallreq_from_ex) begin
      merged = 6'b001111;
    end else if (bus.stallreq_from_id) begin
      merged = 6'b000111;
    end else if (bus.stallreq_from_if) begin
      merged = 6'b000011;
    end

    exc     = (state_q == StRun) && (bus.excepttype_i != '0);
    // Exception wins over a simultaneous watchdog expiry.
    wd_fire = WdEn && (state_q == StRun) && bus.stallreq_from_mem && (wait_q == WdLast) && !exc;
    flush   = exc | wd_fire;
    stall   = flush ? 6'b000000 : merged;

    new_pc = '0;
    if (exc) begin
      new_pc = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
    end else if (wd_fire) begin
      new_pc = EXC_VECTOR;
    end
  end

  always_comb begin
    state_d = flush ? StRecover : StRun;
    wait_d  = '0;
    if (WdEn && (state_q == StRun) && bus.stallreq_from_mem && !flush) begin
      wait_d = wait_q + 1'b1;
    end
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (stall[0] && !flush && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall       = rst ? 6'b000000 : stall;
  assign bus.flush       = rst ? 1'b0 : flush;
  assign bus.new_pc      = rst ? 32'h0 : new_pc;
  assign bus.bus_timeout = rst ? 1'b0 : wd_fire;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  localparam int unsigned TO   = 4;
  localparam logic [31:0] EXCV = 32'h0000_0020;
  localparam logic [31:0] ERET = 32'h0000_000e;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_ctrl_if ifc ();

  pipeline_ctrl #(
    .EXC_VECTOR(EXCV),
    .ERET_CODE (ERET),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: recovering flag, length of current run-mode mem-stall streak, count.
  bit          m_rec;
  int unsigned m_streak;
  logic [31:0] m_cnt;
  int          stopn;
  bit          e_exc, e_fire, e_flush;
  logic [5:0]  e_stall;
  logic [31:0] e_pc;

  initial begin
    m_rec = 0; m_streak = 0; m_cnt = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      check("m_stall", 32'(ifc.stall), 32'h0);
      check("m_flush", 32'(ifc.flush), 32'h0);
      check("m_new_pc", ifc.new_pc, 32'h0);
      check("m_bus_timeout", 32'(ifc.bus_timeout), 32'h0);
      check("m_stall_cnt", ifc.stall_cnt, m_cnt);
      m_rec = 0; m_streak = 0; m_cnt = '0;
    end else begin
      // Number of stopped stages counted from the pc end.
      if (m_rec) stopn = ifc.stallreq_from_if ? 2 : 0;
      else if (ifc.stallreq_from_mem) stopn = 5;
      else if (ifc.stallreq_from_ex) stopn = 4;
      else if (ifc.stallreq_from_id) stopn = 3;
      else if (ifc.stallreq_from_if) stopn = 2;
      else stopn = 0;
      e_exc   = !m_rec && (ifc.excepttype_i != 0);
      e_fire  = !m_rec && !e_exc && ifc.stallreq_from_mem && (m_streak + 1 == TO);
      e_flush = e_exc || e_fire;
      e_stall = e_flush ? 6'd0 : 6'((1 << stopn) - 1);
      e_pc    = e_exc ? ((ifc.excepttype_i == ERET) ? ifc.cp0_epc_i : EXCV) :
                (e_fire ? EXCV : 32'h0);
      check("m_stall", 32'(ifc.stall), 32'(e_stall));
      check("m_flush", 32'(ifc.flush), 32'(e_flush));
      check("m_new_pc", ifc.new_pc, e_pc);
      check("m_bus_timeout", 32'(ifc.bus_timeout), 32'(e_fire));
      check("m_stall_cnt", ifc.stall_cnt, m_cnt);
      if (ifc.cnt_clr) m_cnt = '0;
      else if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_streak = (!m_rec && ifc.stallreq_from_mem && !e_flush) ? m_streak + 1 : 0;
      m_rec = e_flush;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fi, input bit fd, input bit fe, input bit fm,
                       input logic [31:0] exc, input logic [31:0] epc, input bit clr);
    ifc.stallreq_from_if  = fi;
    ifc.stallreq_from_id  = fd;
    ifc.stallreq_from_ex  = fe;
    ifc.stallreq_from_mem = fm;
    ifc.excepttype_i      = exc;
    ifc.cp0_epc_i         = epc;
    ifc.cnt_clr           = clr;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_flush", 32'(ifc.flush), 32'h0);
    check("reset_stall_cnt", ifc.stall_cnt, 32'h0);

    // Stall priority
    step(); drive(0, 1, 1, 0, 0, 0, 0); @(negedge clk);
    check("prio_id_ex", 32'(ifc.stall), 32'h0f);
    step(); drive(1, 1, 1, 1, 0, 0, 0); @(negedge clk);
    check("prio_all", 32'(ifc.stall), 32'h1f);
    step(); drive(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    check("prio_none", 32'(ifc.stall), 32'h00);

    // Non-eret exception under mem stall, then RECOVER masks everything but if
    step(); drive(0, 0, 0, 1, 32'h8, 0, 0); @(negedge clk);
    check("exc_flush", 32'(ifc.flush), 32'h1);
    check("exc_stall", 32'(ifc.stall), 32'h0);
    check("exc_pc", ifc.new_pc, 32'h20);
    step(); drive(1, 1, 1, 1, 32'h8, 0, 0); @(negedge clk);
    check("recover_flush", 32'(ifc.flush), 32'h0);
    check("recover_stall", 32'(ifc.stall), 32'h03);

    // Eret
    step(); drive(0, 0, 0, 0, 32'he, 32'h1234, 0); @(negedge clk);
    check("eret_flush", 32'(ifc.flush), 32'h1);
    check("eret_pc", ifc.new_pc, 32'h1234);
    step(); drive(0, 0, 0, 0, 0, 0, 0);

    // Watchdog: 4 consecutive mem-stall cycles
    step(); drive(0, 0, 0, 1, 0, 0, 0);
    step(); step(); @(negedge clk);
    check("wd_3rd_quiet", 32'(ifc.bus_timeout), 32'h0);
    step(); @(negedge clk);
    check("wd_fire", 32'(ifc.bus_timeout), 32'h1);
    check("wd_flush", 32'(ifc.flush), 32'h1);
    check("wd_pc", ifc.new_pc, 32'h20);
    step(); drive(0, 0, 0, 0, 0, 0, 0);
    // 3 on, 1 off, 3 on
    step(); drive(0, 0, 0, 1, 0, 0, 0);
    step(); step(); step(); drive(0, 0, 0, 0, 0, 0, 0);
    step(); drive(0, 0, 0, 1, 0, 0, 0);
    step(); step(); @(negedge clk);
    check("wd_gap_quiet", 32'(ifc.bus_timeout), 32'h0);
    step(); drive(0, 0, 0, 0, 0, 0, 0);

    // Stall counter
    step(); drive(0, 0, 0, 0, 0, 0, 1);
    step(); drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    check("cnt_cleared", ifc.stall_cnt, 32'h0);
    for (int i = 0; i < 9; i++) step();
    step(); drive(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    check("cnt_ten", ifc.stall_cnt, 32'd10);
    step(); drive(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    check("cnt_after_clr", ifc.stall_cnt, 32'h0);
    step();
    #1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step(); step(); step(); @(negedge clk);
    check("cnt_saturate", ifc.stall_cnt, 32'hFFFF_FFFF);
    step(); drive(0, 0, 0, 0, 0, 0, 1);

    // Reset on the 3rd mem-stall cycle
    step(); drive(0, 0, 0, 1, 0, 0, 0);
    step(); step(); rst = 1'b1;
    step(); rst = 1'b0;
    step(); step(); @(negedge clk);
    check("rst_mid_quiet", 32'(ifc.bus_timeout), 32'h0);
    step(); @(negedge clk);
    check("rst_mid_fire", 32'(ifc.bus_timeout), 32'h1);
    step(); drive(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step();
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 7,
            ($urandom_range(0, 19) == 0) ?
              (($urandom_range(0, 1) == 1) ? ERET : 32'($urandom_range(1, 15))) : 32'h0,
            $urandom, $urandom_range(0, 29) == 0);
    end
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencing controller for the 6-stage CPU pipeline (pc, if, id, ex, mem, wb). It merges per-stage stall requests into the shared `stall[5:0]` vector consumed by every inter-stage register, including the mem/wb register. It also sequences exception flushes and supplies the redirect PC. A memory-bus watchdog converts a hung data access into a synthetic exception, and a saturating counter records stall cycles for performance analysis.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h0000_0020: handler PC for every non-eret exception and for bus timeout.
- `ERET_CODE`, default 32'h0000_000e: `excepttype_i` value that selects `cp0_epc_i` as the redirect PC.
- `TIMEOUT`, default 255: number of consecutive mem-stall cycles that triggers a bus timeout. A value of 0 disables the watchdog.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `stallreq_from_if`, input, 1: instruction bus wait.
- `stallreq_from_id`, input, 1: load-use hazard.
- `stallreq_from_ex`, input, 1: multi-cycle ex operation (div, madd) busy.
- `stallreq_from_mem`, input, 1: data bus wait.
- `excepttype_i`, input, 32: exception code from the mem stage. Nonzero means an exception is present.
- `cp0_epc_i`, input, 32: current EPC from CP0.
- `cnt_clr`, input, 1: clears `stall_cnt`.
- `stall`, output, 6: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb. 1 means STOP.
- `flush`, output, 1: clears all pipeline registers at the next edge.
- `new_pc`, output, 32: redirect PC. Valid only while `flush`=1, otherwise 0.
- `bus_timeout`, output, 1: one-cycle pulse when the watchdog fires.
- `stall_cnt`, output, 32: stall-cycle counter.

## Operation
FSM states:
- RUN:
  - Normal stall merging.
  - Exception and watchdog detection are active.
- RECOVER:
  - Lasts exactly 1 cycle, entered after any flush.
  - `stallreq_from_id`, `stallreq_from_ex`, `stallreq_from_mem` and `excepttype_i` are ignored, because they come from flushed bubbles.
  - Only `stallreq_from_if` is honored.
  - Always returns to RUN.

Stall merge is combinational, highest priority first:
- mem request: 6'b011111
- ex request: 6'b001111
- id request: 6'b000111
- if request: 6'b000011
- no request: 6'b000000

Exception (RUN, `excepttype_i`≠0):
- `flush`=1 and `stall`=0 in that cycle, regardless of stall requests.
- `new_pc` = `cp0_epc_i` if `excepttype_i`==`ERET_CODE`, else `EXC_VECTOR`.
- Next state RECOVER.

Watchdog:
- `mem_wait_cnt` has width ≥ clog2(TIMEOUT+1).
- Increments on each RUN cycle with `stallreq_from_mem`=1 and no exception.
- Clears on any cycle with `stallreq_from_mem`=0, in RECOVER, or on flush.
- Fires in the RUN cycle where `stallreq_from_mem`=1 and `mem_wait_cnt`==TIMEOUT-1, i.e. the TIMEOUT-th consecutive stalled cycle. In that cycle:
  - `bus_timeout`=1, `flush`=1, `stall`=0, `new_pc`=`EXC_VECTOR`.
  - Counter clears; next state RECOVER.

Simultaneous events:
- Exception and watchdog in the same cycle: the exception wins. `new_pc` follows the exception rule, `bus_timeout`=0, and the counter clears.

`stall_cnt`:
- +1 on every cycle with `stall[0]`=1 and `flush`=0.
- Saturates at 32'hFFFF_FFFF.
- `cnt_clr` has priority over increment; the count reads 0 on the following cycle.

## Timing
- `stall`, `flush`, `new_pc` and `bus_timeout` are combinational from inputs and registered state, with zero-cycle latency. Consuming stage registers act on the same edge.
- Registered state: FSM, `mem_wait_cnt`, `stall_cnt`.
- Reset values, and output values in the cycle after `rst` is sampled high:
  - state = RUN
  - `mem_wait_cnt` = 0
  - `stall_cnt` = 0
  - `flush` = 0, `bus_timeout` = 0, `new_pc` = 0
  - `stall` follows the merged requests
- While `rst`=1: all combinational outputs are forced to 0 (`stall`=0, `flush`=0, `new_pc`=0, `bus_timeout`=0).
- Reset asserted mid-RECOVER or mid-watchdog-count: state and counters return to reset values at that edge; no pending flush survives.
- A flush is never asserted in two consecutive cycles, because RECOVER masks `excepttype_i`.
- With `TIMEOUT`=0 the watchdog never fires, and `mem_wait_cnt` stays at 0.

## Test plan
- **Stall priority.** Drive `stallreq_from_id`=1 and `stallreq_from_ex`=1 together. Required: `stall`=6'b001111. Then assert all four requests. Required: 6'b011111. Release all. Required: 6'b000000.
- **Non-eret exception under stall.** `excepttype_i`=32'h0000_0008 with `stallreq_from_mem`=1. Required that cycle: `flush`=1, `stall`=0, `new_pc`=32'h0000_0020. Next cycle: with `excepttype_i` still 8, `flush`=0, and `stall` reflects only `stallreq_from_if`.
- **Eret.** `excepttype_i`=32'h0000_000e, `cp0_epc_i`=32'h0000_1234. Required: `flush`=1, `new_pc`=32'h0000_1234.
- **Watchdog (`TIMEOUT`=4).**
  - `stallreq_from_mem` held high for 4 cycles: `bus_timeout`=1 and `flush`=1 on the 4th cycle, `new_pc`=32'h20.
  - Held for 3 cycles, dropped for 1, then held for 3: no timeout.
- **Stall counter.** 10 cycles with `stall[0]`=1, then `cnt_clr`. Required: `stall_cnt`=10, then 0. A force-preloaded count of 32'hFFFF_FFFF stays at FFFF_FFFF under further stall.
- **Reset mid-count.** `rst`=1 on the 3rd mem-stall cycle with `TIMEOUT`=4. After release, 3 more stall cycles produce no timeout; the 4th produces the timeout.
